// File: rtl/simple_circuit_tester.sv
// simple_circuit_tester: walks all eight {C,B,A} vectors into the 3-input
// circuit under test, waits SETTLE_CYCLES per vector, samples the returned
// x/y, compares them against x = (A & B) | ~C and y = ~C, and reports
// pass/fail, a mismatch count and the first failing vector.
module simple_circuit_tester #(
    parameter int unsigned SETTLE_CYCLES = 2   // legal range 1..255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dut_x,
    input  logic       dut_y,
    output logic [2:0] abc_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] first_fail,
    output logic       first_fail_valid
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    // Last settle count before the vector is sampled.
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [2:0] VEC_LAST    = 3'd7;

    state_t     r_state;
    state_t     w_next_state;

    logic [2:0] r_vec;
    logic [7:0] r_settle_cnt;
    logic [2:0] r_abc_out;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [3:0] r_err_count;
    logic [2:0] r_first_fail;
    logic       r_first_fail_valid;

    logic       w_start_ok;
    logic       w_settle_end;
    logic       w_last_vec;
    logic       w_gx;
    logic       w_gy;
    logic       w_mismatch;
    logic       w_sampling;

    // Start is honoured only from the idle or finished states.
    assign w_start_ok   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_settle_end = (r_settle_cnt == SETTLE_LAST);
    assign w_last_vec   = (r_vec == VEC_LAST);
    assign w_sampling   = (r_state == ST_SAMPLE);

    // Golden response for the vector currently driven; bit0 = A, bit1 = B, bit2 = C.
    assign w_gx = (r_vec[0] & r_vec[1]) | ~r_vec[2];
    assign w_gy = ~r_vec[2];

    // A vector counts as one mismatch even if both x and y are wrong.
    assign w_mismatch = ({dut_y, dut_x} != {w_gy, w_gx});

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values of the others, independent of block order.
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: the default is assigned first so no path leaves w_next_state
        // unassigned, which would otherwise infer a latch.
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (w_settle_end) begin
                    w_next_state = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (w_last_vec) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_SETTLE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_next_state = ST_SETTLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Vector sequencing, settle timing and the registered drive vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec        <= 3'd0;
            r_settle_cnt <= 8'd0;
            r_abc_out    <= 3'd0;
        end else if (w_start_ok) begin
            r_vec        <= 3'd0;
            r_settle_cnt <= 8'd0;
            r_abc_out    <= 3'd0;
        end else begin
            unique case (r_state)
                ST_SETTLE: begin
                    r_settle_cnt <= r_settle_cnt + 8'd1;
                end
                ST_SAMPLE: begin
                    r_settle_cnt <= 8'd0;
                    if (w_last_vec) begin
                        // Run is over: stop driving the circuit.
                        r_abc_out <= 3'd0;
                    end else begin
                        r_vec     <= r_vec + 3'd1;
                        r_abc_out <= r_vec + 3'd1;
                    end
                end
                default: begin
                    r_abc_out <= 3'd0;
                end
            endcase
        end
    end

    // Status flags follow the next state so busy/done line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next_state == ST_SETTLE) || (w_next_state == ST_SAMPLE);
            r_done <= (w_next_state == ST_DONE);
        end
    end

    // Compare results: error count, first failing vector and the final verdict.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count        <= 4'd0;
            r_first_fail       <= 3'd0;
            r_first_fail_valid <= 1'b0;
            r_pass             <= 1'b0;
        end else if (w_start_ok) begin
            r_err_count        <= 4'd0;
            r_first_fail       <= 3'd0;
            r_first_fail_valid <= 1'b0;
            r_pass             <= 1'b0;
        end else if (w_sampling) begin
            if (w_mismatch) begin
                r_err_count <= r_err_count + 4'd1;
                if (!r_first_fail_valid) begin
                    r_first_fail       <= r_vec;
                    r_first_fail_valid <= 1'b1;
                end
            end
            // The verdict must include the compare made on the last vector.
            if (w_last_vec) begin
                r_pass <= (r_err_count == 4'd0) && !w_mismatch;
            end
        end
    end

    assign abc_out          = r_abc_out;
    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign err_count        = r_err_count;
    assign first_fail       = r_first_fail;
    assign first_fail_valid = r_first_fail_valid;

endmodule

// File: tb/tb_simple_circuit_tester.sv
// Bench for simple_circuit_tester: a behavioural circuit under test (with
// optional stuck-at faults) loops back to two tester instances (settle 2
// and settle 1). Expected drive vectors and run results are queued when a
// run is started and popped as the tester produces them.
module tb_simple_circuit_tester;

    typedef struct packed {
        logic [3:0] err;
        logic [2:0] ff;
        logic       ffv;
        logic       pass;
    } res_t;

    localparam int FAULT_NONE  = 0;
    localparam int FAULT_Y_SA0 = 1;
    localparam int FAULT_X_SA1 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start;
    logic sel;
    int   fault;

    int n_cmp = 0;
    int n_mis = 0;

    // Golden tables written out by vector index (bit v of the constant).
    logic [7:0] gx_tab = 8'h8F;
    logic [7:0] gy_tab = 8'h0F;

    logic [2:0] exp_abc_q[$];
    res_t       exp_res_q[$];

    logic       start_a, start_b;
    logic [2:0] abc_a, abc_b;
    logic       x_a, y_a, x_b, y_b;
    logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [3:0] err_a, err_b;
    logic [2:0] ff_a, ff_b;
    logic       ffv_a, ffv_b;

    // Behavioural circuit under test with planted faults.
    function automatic logic cut_x(input logic [2:0] v, input int f);
        logic gx;
        gx = (v[0] & v[1]) | ~v[2];
        return (f == FAULT_X_SA1) ? 1'b1 : gx;
    endfunction

    function automatic logic cut_y(input logic [2:0] v, input int f);
        return (f == FAULT_Y_SA0) ? 1'b0 : ~v[2];
    endfunction

    assign x_a = cut_x(abc_a, fault);
    assign y_a = cut_y(abc_a, fault);
    assign x_b = cut_x(abc_b, fault);
    assign y_b = cut_y(abc_b, fault);

    assign start_a = start & ~sel;
    assign start_b = start &  sel;

    simple_circuit_tester #(.SETTLE_CYCLES(2)) u_dut_a (
        .clk              (clk),
        .rst              (rst),
        .start            (start_a),
        .dut_x            (x_a),
        .dut_y            (y_a),
        .abc_out          (abc_a),
        .busy             (busy_a),
        .done             (done_a),
        .pass             (pass_a),
        .err_count        (err_a),
        .first_fail       (ff_a),
        .first_fail_valid (ffv_a)
    );

    simple_circuit_tester #(.SETTLE_CYCLES(1)) u_dut_b (
        .clk              (clk),
        .rst              (rst),
        .start            (start_b),
        .dut_x            (x_b),
        .dut_y            (y_b),
        .abc_out          (abc_b),
        .busy             (busy_b),
        .done             (done_b),
        .pass             (pass_b),
        .err_count        (err_b),
        .first_fail       (ff_b),
        .first_fail_valid (ffv_b)
    );

    // Observation mux: the selected instance is the one being checked.
    logic [2:0] m_abc;
    logic       m_busy, m_done, m_pass, m_ffv;
    logic [3:0] m_err;
    logic [2:0] m_ff;
    assign m_abc  = sel ? abc_b  : abc_a;
    assign m_busy = sel ? busy_b : busy_a;
    assign m_done = sel ? done_b : done_a;
    assign m_pass = sel ? pass_b : pass_a;
    assign m_err  = sel ? err_b  : err_a;
    assign m_ff   = sel ? ff_b   : ff_a;
    assign m_ffv  = sel ? ffv_b  : ffv_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic res_t predict(input int f);
        res_t r;
        logic [2:0] v;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            if ((cut_x(v, f) != gx_tab[i]) || (cut_y(v, f) != gy_tab[i])) begin
                if (!r.ffv) begin
                    r.ff  = v;
                    r.ffv = 1'b1;
                end
                r.err = r.err + 4'd1;
            end
        end
        r.pass = (r.err == 4'd0);
        return r;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_abc"},  32'(m_abc),  0);
        check({tag, "_busy"}, 32'(m_busy), 0);
        check({tag, "_done"}, 32'(m_done), 0);
        check({tag, "_pass"}, 32'(m_pass), 0);
        check({tag, "_err"},  32'(m_err),  0);
        check({tag, "_ff"},   32'(m_ff),   0);
        check({tag, "_ffv"},  32'(m_ffv),  0);
    endtask

    // One full run. Called at #1 after a rising edge; start is sampled at the
    // next edge (t). Optionally re-pulses start mid-run, which must be ignored.
    task automatic run(input bit use_b, input int settle, input int f, input bit repulse);
        res_t       er;
        logic [2:0] ea;
        sel   = use_b;
        fault = f;
        for (int v = 0; v < 8; v++) begin
            for (int c = 0; c <= settle; c++) begin
                exp_abc_q.push_back(3'(v));
            end
        end
        exp_res_q.push_back(predict(f));

        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 8 * (settle + 1); k++) begin
            ea = exp_abc_q.pop_front();
            check("run_busy", 32'(m_busy), 1);
            check("run_done", 32'(m_done), 0);
            check("run_abc",  32'(m_abc),  32'(ea));
            if (repulse && (k == 4)) begin
                start = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        er = exp_res_q.pop_front();
        check("end_done", 32'(m_done), 1);
        check("end_busy", 32'(m_busy), 0);
        check("end_abc",  32'(m_abc),  0);
        check("end_pass", 32'(m_pass), 32'(er.pass));
        check("end_err",  32'(m_err),  32'(er.err));
        check("end_ff",   32'(m_ff),   32'(er.ff));
        check("end_ffv",  32'(m_ffv),  32'(er.ffv));
        // done must persist while start stays low.
        @(posedge clk);
        #1;
        check("done_hold", 32'(m_done), 1);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        sel   = 1'b0;
        fault = FAULT_NONE;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("rst_a");
        sel = 1'b1;
        check_reset_values("rst_b");
        sel = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Correct circuit, settle 2, with a start re-pulse while busy.
        run(1'b0, 2, FAULT_NONE, 1'b1);
        // y stuck at 0: vectors 0..3 fail.
        run(1'b0, 2, FAULT_Y_SA0, 1'b0);
        // Restart from DONE after a failing run: counters clear, run passes.
        run(1'b0, 2, FAULT_NONE, 1'b0);
        // x stuck at 1: vectors 4..6 fail.
        run(1'b0, 2, FAULT_X_SA1, 1'b0);
        // Settle 1 instance, correct circuit.
        run(1'b1, 1, FAULT_NONE, 1'b0);

        // Reset mid-run at vector 3, with start held (must be ignored under rst).
        sel   = 1'b0;
        fault = FAULT_NONE;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 40 && m_abc != 3'd3; i++) begin
            @(posedge clk);
            #1;
        end
        check("reach_vec3", 32'(m_abc), 3);
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("midrst");
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_rst", 32'(m_busy), 0);
        run(1'b0, 2, FAULT_NONE, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/simple_circuit_tester.md
# simple_circuit_tester

Self-checking stimulus generator and response checker for the 3-input simple-circuit logic (x = (A AND B) OR NOT C, y = NOT C). It walks all eight A/B/C input combinations and drives them to the circuit under test. After each vector it waits a programmable settle time, samples the returned x and y, and compares them against the golden function. It reports pass/fail, a mismatch count and the first failing vector, and sits on the driving side of the circuit for on-chip or bench loopback checking.

## Interface
Parameters
- SETTLE_CYCLES, default 2: cycles a vector is held before sampling; legal range 1..255.

Ports
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins a run when sampled high in IDLE or DONE; ignored otherwise.
- dut_x  in  1  x returned from the circuit under test.
- dut_y  in  1  y returned from the circuit under test.
- abc_out  out  3  vector driven to the circuit under test: bit0 = A, bit1 = B, bit2 = C.
- busy  out  1  high while a run is in progress (SETTLE or SAMPLE).
- done  out  1  high in DONE; stays high until the next start or rst.
- pass  out  1  valid when done = 1; 1 = zero mismatches.
- err_count  out  4  number of mismatching vectors, 0..8.
- first_fail  out  3  value of the first mismatching vector.
- first_fail_valid  out  1  first_fail holds a captured value.

## Operation
- Golden function for vector v = {C, B, A}:
  - gx = (A & B) | ~C
  - gy = ~C
- Golden table:
  - gx = 1 for v = 0, 1, 2, 3 and 7; gx = 0 for v = 4, 5, 6.
  - gy = 1 for v = 0..3; gy = 0 for v = 4..7.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE/DONE, start = 1:
  - clear vec, settle_cnt, err_count, first_fail and first_fail_valid; clear done and pass.
  - go to SETTLE.
- SETTLE:
  - abc_out = vec (registered).
  - settle_cnt increments each cycle.
  - when settle_cnt = SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE:
  - compare {dut_y, dut_x} against {gy, gx} for vec.
  - on mismatch, increment err_count; if first_fail_valid = 0, capture first_fail = vec and set first_fail_valid = 1.
  - if vec = 7, go to DONE and set pass = (final err_count == 0), including this cycle's compare.
  - otherwise vec++, settle_cnt = 0, go to SETTLE.
- DONE:
  - done = 1, busy = 0, abc_out = 0.
  - err_count and first_fail hold until the next start.
- One mismatch is counted per vector, even when both x and y differ.
- vec is 3 bits; the run ends at 7 and never wraps.
- start while busy = 1 has no effect. start held high in DONE restarts the run.

## Timing
- Reset values, held the cycle after rst is sampled high:
  - abc_out = 0, busy = 0, done = 0, pass = 0, err_count = 0, first_fail = 0, first_fail_valid = 0; state = IDLE.
- rst mid-run aborts the run at that edge; start is ignored in any cycle where rst = 1.
- start sampled at edge t:
  - busy = 1 and abc_out = 0 from cycle t+1.
  - each vector occupies SETTLE_CYCLES+1 cycles, so vector k is driven from t+1+k*(SETTLE_CYCLES+1).
  - dut_x/dut_y are sampled in the last cycle of each vector.
  - done and pass are valid from cycle t+1+8*(SETTLE_CYCLES+1); that is t+25 for the default.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Correct DUT model, SETTLE_CYCLES = 2, start at t -> abc_out steps 0..7, every 3 cycles from t+1; done = 1 and pass = 1 at t+25; err_count = 0, first_fail_valid = 0.
- dut_y stuck at 0 -> mismatches on vectors 0..3; err_count = 4, first_fail = 0, pass = 0.
- dut_x stuck at 1 -> mismatches on vectors 4, 5, 6; err_count = 3, first_fail = 4, pass = 0.
- SETTLE_CYCLES = 1, correct model -> done at t+17, pass = 1.
- rst pulsed when vec = 3 -> next cycle all outputs at reset values and state IDLE; a later start produces a full fresh run with pass = 1.
- start re-pulsed while busy -> ignored, timing unchanged; start in DONE after a failing run -> counters clear and the new run passes with the correct model.
